// File: rtl/reg_pair_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_pair_sequencer_pkg
// Purpose  : Shared encodings for the 16-bit register-pair sequencer:
//            register selects, pair ops, pair selects, flag bit positions
//            and the pair-to-{hi,lo} register mapping.
// Revision : 1.0 - initial release
// ============================================================================
package reg_pair_sequencer_pkg;

   typedef enum logic [2:0] {
      reg_A = 3'd0,
      reg_B = 3'd1,
      reg_C = 3'd2,
      reg_D = 3'd3,
      reg_E = 3'd4,
      reg_H = 3'd5,
      reg_L = 3'd6,
      reg_F = 3'd7
   } reg_sel_t;

   typedef enum logic [1:0] {
      PO_LD_IMM = 2'd0,
      PO_INC    = 2'd1,
      PO_DEC    = 2'd2,
      PO_ADD_HL = 2'd3
   } pair_op_t;

   typedef enum logic [1:0] {
      P_BC  = 2'd0,
      P_DE  = 2'd1,
      P_HL  = 2'd2,
      P_BAD = 2'd3
   } pair_sel_t;

   // Bit positions inside F = {Z,N,H,C}
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_H = 1;
   localparam int FLAG_C = 0;

   typedef struct packed {
      reg_sel_t hi;
      reg_sel_t lo;
   } reg_pair_t;

   // High/low 8-bit registers of a pair; the illegal select maps to A/A
   function automatic reg_pair_t pair_regs(input pair_sel_t p);
      reg_pair_t r;
      case (p)
         P_BC:    begin r.hi = reg_B; r.lo = reg_C; end
         P_DE:    begin r.hi = reg_D; r.lo = reg_E; end
         P_HL:    begin r.hi = reg_H; r.lo = reg_L; end
         default: begin r.hi = reg_A; r.lo = reg_A; end
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_pair_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_pair_sequencer_if
// Purpose  : Request/status handshake, control-unit pass-through and
//            register-file port bundle of the register-pair sequencer.
//            master = control unit + register file side, slave = sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_pair_sequencer_if;
   import reg_pair_sequencer_pkg::*;

   // request / status
   logic        start;
   pair_op_t    op;
   pair_sel_t   pair_sel;
   pair_sel_t   src_sel;
   logic [15:0] imm16;
   logic        busy;
   logic        done;
   logic        err;

   // control-unit register-file controls
   reg_sel_t    cpu_reg_selA;
   reg_sel_t    cpu_reg_selB;
   logic [1:0]  cpu_load_en;
   logic [7:0]  cpu_reg_input;
   logic [15:0] cpu_addr_input;
   logic [3:0]  cpu_flags_in;

   // register-file side
   logic [7:0]  rf_reg_outA;
   logic [7:0]  rf_reg_outB;
   logic [3:0]  rf_flags;
   reg_sel_t    rf_reg_selA;
   reg_sel_t    rf_reg_selB;
   logic [1:0]  rf_load_en;
   logic [7:0]  rf_reg_input;
   logic [15:0] rf_addr_input;
   logic [3:0]  rf_flags_in;

   modport master (
      output start, op, pair_sel, src_sel, imm16,
      output cpu_reg_selA, cpu_reg_selB, cpu_load_en, cpu_reg_input,
      output cpu_addr_input, cpu_flags_in,
      output rf_reg_outA, rf_reg_outB, rf_flags,
      input  busy, done, err,
      input  rf_reg_selA, rf_reg_selB, rf_load_en, rf_reg_input,
      input  rf_addr_input, rf_flags_in
   );

   modport slave (
      input  start, op, pair_sel, src_sel, imm16,
      input  cpu_reg_selA, cpu_reg_selB, cpu_load_en, cpu_reg_input,
      input  cpu_addr_input, cpu_flags_in,
      input  rf_reg_outA, rf_reg_outB, rf_flags,
      output busy, done, err,
      output rf_reg_selA, rf_reg_selB, rf_load_en, rf_reg_input,
      output rf_addr_input, rf_flags_in
   );

endinterface
`default_nettype wire

// File: rtl/reg_pair_sequencer_pair_alu16.sv
`default_nettype none
// ============================================================================
// Module   : pair_alu16
// Purpose  : Combinational 16-bit pair arithmetic. INC/DEC wrap modulo 2^16,
//            ADD reports half carry (out of bit 11) and carry (out of bit 15).
//            LD_IMM passes operand b through unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module pair_alu16
   import reg_pair_sequencer_pkg::*;
(
   input  pair_op_t    i_op,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_result,
   output logic        o_h,
   output logic        o_c
);

   logic [16:0] w_sum17;
   logic [12:0] w_sum12;

   assign w_sum17 = {1'b0, i_a} + {1'b0, i_b};
   assign w_sum12 = {1'b0, i_a[11:0]} + {1'b0, i_b[11:0]};

   // Select the result and carries for the requested op
   always_comb begin
      o_result = i_b;
      o_h      = 1'b0;
      o_c      = 1'b0;
      case (i_op)
         PO_INC:    o_result = i_a + 16'd1;
         PO_DEC:    o_result = i_a - 16'd1;
         PO_ADD_HL: begin
            o_result = w_sum17[15:0];
            o_h      = w_sum12[12];
            o_c      = w_sum17[16];
         end
         default:   o_result = i_b;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/reg_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_pair_sequencer
// Purpose  : Multi-cycle controller for 16-bit register-pair ops
//            (LD rr,nn / INC rr / DEC rr / ADD HL,rr) on the 8-bit register
//            file. Passes control-unit controls through while idle and owns
//            the register-file ports while busy.
// Revision : 1.0 - initial release
// ============================================================================
module reg_pair_sequencer
   import reg_pair_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   reg_pair_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD0  = 3'd1,
      ST_RD1  = 3'd2,
      ST_WR   = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   state_t      r_state;
   pair_op_t    r_op;
   pair_sel_t   r_pair;
   pair_sel_t   r_src;
   logic [15:0] r_imm;
   logic [15:0] r_tmpA;
   logic [15:0] r_tmpB;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic        w_bad;
   logic [15:0] w_alu_b;
   logic [15:0] w_alu_result;
   logic        w_alu_h;
   logic        w_alu_c;
   reg_pair_t   w_rd_pair;
   reg_pair_t   w_wr_pair;
   reg_sel_t    w_sel_a;
   reg_sel_t    w_sel_b;
   logic [1:0]  w_load_en;
   logic [7:0]  w_reg_input;
   logic [15:0] w_addr;
   logic [3:0]  w_flags;

   // Source selector only matters for ADD HL,rr
   assign w_bad = (bus.pair_sel == P_BAD) ||
                  ((bus.op == PO_ADD_HL) && (bus.src_sel == P_BAD));

   // LD_IMM result is the immediate, routed through the ALU's b operand
   assign w_alu_b = (r_op == PO_LD_IMM) ? r_imm : r_tmpB;

   pair_alu16 u_alu (
      .i_op     (r_op),
      .i_a      (r_tmpA),
      .i_b      (w_alu_b),
      .o_result (w_alu_result),
      .o_h      (w_alu_h),
      .o_c      (w_alu_c)
   );

   // Sequencer FSM with registered busy/done/err
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= PO_LD_IMM;
         r_pair  <= P_BC;
         r_src   <= P_BC;
         r_imm   <= 16'h0000;
         r_tmpA  <= 16'h0000;
         r_tmpB  <= 16'h0000;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_op   <= bus.op;
                  r_pair <= bus.pair_sel;
                  r_src  <= bus.src_sel;
                  r_imm  <= bus.imm16;
                  r_busy <= 1'b1;
                  if (w_bad) begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else if (bus.op == PO_LD_IMM) begin
                     r_state <= ST_WR;
                  end else begin
                     r_state <= ST_RD0;
                  end
               end
            end
            ST_RD0: begin
               r_tmpA  <= {bus.rf_reg_outA, bus.rf_reg_outB};
               r_state <= (r_op == PO_ADD_HL) ? ST_RD1 : ST_WR;
            end
            ST_RD1: begin
               r_tmpB  <= {bus.rf_reg_outA, bus.rf_reg_outB};
               r_state <= ST_WR;
            end
            ST_WR: begin
               r_state <= ST_FIN;
               r_done  <= 1'b1;
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Register-file port mux: pass-through when idle, sequencer-owned otherwise
   always_comb begin
      w_rd_pair   = pair_regs((r_state == ST_RD1) ? r_src : r_pair);
      w_wr_pair   = pair_regs(r_pair);
      w_sel_a     = reg_A;
      w_sel_b     = reg_A;
      w_load_en   = 2'b00;
      w_reg_input = 8'h00;
      w_addr      = 16'h0000;
      w_flags     = bus.rf_flags;
      case (r_state)
         ST_IDLE: begin
            w_sel_a     = bus.cpu_reg_selA;
            w_sel_b     = bus.cpu_reg_selB;
            w_load_en   = bus.cpu_load_en;
            w_reg_input = bus.cpu_reg_input;
            w_addr      = bus.cpu_addr_input;
            w_flags     = bus.cpu_flags_in;
         end
         ST_RD0, ST_RD1: begin
            w_sel_a = w_rd_pair.hi;
            w_sel_b = w_rd_pair.lo;
         end
         ST_WR: begin
            w_load_en = 2'b10;
            w_sel_a   = w_wr_pair.hi;
            w_addr    = w_alu_result;
            if (r_op == PO_ADD_HL) begin
               w_flags[FLAG_Z] = bus.rf_flags[FLAG_Z];
               w_flags[FLAG_N] = 1'b0;
               w_flags[FLAG_H] = w_alu_h;
               w_flags[FLAG_C] = w_alu_c;
            end
         end
         default: ;
      endcase
   end

   assign bus.rf_reg_selA   = w_sel_a;
   assign bus.rf_reg_selB   = w_sel_b;
   assign bus.rf_load_en    = w_load_en;
   assign bus.rf_reg_input  = w_reg_input;
   assign bus.rf_addr_input = w_addr;
   assign bus.rf_flags_in   = w_flags;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.err           = r_err;

endmodule
`default_nettype wire
